// File: rtl/adc_frame_capture.sv
// ADC frame capture: arms on start, optionally waits for a rising level crossing
// (or a strobe timeout), then writes DEPTH decimated samples into an external RAM.
//
// state     | meaning
// IDLE      | waiting for start
// ARM       | one cycle: latch trigger setup, clear counters
// WAIT_TRIG | watching strobed samples for a rising crossing of trig_level
// CAPTURE   | writing one sample per strobe, addresses 0..DEPTH-1
// DONE      | frame complete, frame_done held until ack
module adc_frame_capture #(
   parameter int DW           = 12,
   parameter int AW           = 10,
   parameter int DECIM        = 1,
   parameter int TRIG_TIMEOUT = 4096
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [DW-1:0] adc_data,
   input  logic          start,
   input  logic          trig_en,
   input  logic [DW-1:0] trig_level,
   input  logic          ack,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          frame_done,
   output logic          timed_out
);

   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int TCW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_TRIG, S_CAPTURE, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] adc_q, adc_prev, level_q;
   logic [DCW-1:0] dec_cnt;
   logic [TCW-1:0] strb_cnt;
   logic [AW-1:0] wr_cnt;
   logic          strobe, crossing, timeout_hit, last_addr;
   logic          do_write, set_timeout;

   assign strobe      = ((state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE))
                        && (dec_cnt == DCW'(DECIM - 1));
   assign crossing    = (adc_prev < level_q) && (adc_q >= level_q);
   assign timeout_hit = (strb_cnt == TCW'(TRIG_TIMEOUT - 1));
   assign last_addr   = (wr_cnt == {AW{1'b1}});

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      do_write    = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         S_IDLE:      if (start) state_d = S_ARM;
         S_ARM:       state_d = trig_en ? S_WAIT_TRIG : S_CAPTURE;
         S_WAIT_TRIG: begin
            if (strobe) begin
               // the crossing sample itself is the first word of the frame
               if (crossing) begin
                  do_write = 1'b1;
                  state_d  = last_addr ? S_DONE : S_CAPTURE;
               end else if (timeout_hit) begin
                  set_timeout = 1'b1;
                  state_d     = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (strobe) begin
               do_write = 1'b1;
               if (last_addr) state_d = S_DONE;
            end
         end
         S_DONE:      if (ack) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         adc_q     <= '0;
         adc_prev  <= '0;
         level_q   <= '0;
         dec_cnt   <= '0;
         strb_cnt  <= '0;
         wr_cnt    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         timed_out <= 1'b0;
      end else begin
         adc_q <= adc_data;
         wr_en <= do_write;
         if (do_write) begin
            wr_addr <= wr_cnt;
            wr_data <= adc_q;
            wr_cnt  <= wr_cnt + 1'b1;
         end
         if (set_timeout) timed_out <= 1'b1;
         if (state_q == S_ARM) begin
            dec_cnt   <= '0;
            strb_cnt  <= '0;
            wr_cnt    <= '0;
            timed_out <= 1'b0;
            level_q   <= trig_level;
            // first strobe after arming has no predecessor, so it cannot cross
            adc_prev  <= '1;
         end else if ((state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE)) begin
            dec_cnt <= strobe ? '0 : dec_cnt + 1'b1;
            if (strobe) begin
               adc_prev <= adc_q;
               if (state_q == S_WAIT_TRIG) strb_cnt <= strb_cnt + 1'b1;
            end
         end
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);

endmodule

// File: doc/adc_frame_capture.md
ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 Parameter DW, default 12: ADC sample width (unsigned).
REQ-002 Parameter AW, default 10: RAM address width; frame depth DEPTH = 2^AW.
REQ-003 Parameter DECIM, default 1: sample strobe every DECIM clocks; values below 1 not supported.
REQ-004 Parameter TRIG_TIMEOUT, default 4096: strobes to wait for trigger before forced capture.
REQ-005 sys_clk  in  1  single clock for all logic.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 adc_data  in  DW  unsigned ADC sample, sampled every clock.
REQ-008 start  in  1  one-cycle pulse arming a capture.
REQ-009 trig_en  in  1  1 = wait for rising level crossing; 0 = capture immediately.
REQ-010 trig_level  in  DW  unsigned trigger threshold.
REQ-011 ack  in  1  consumer (RAM-state stage) has read the frame.
REQ-012 wr_en  out  1  RAM write strobe.
REQ-013 wr_addr  out  AW  RAM write address.
REQ-014 wr_data  out  DW  RAM write data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 frame_done  out  1  level: full frame in RAM, held until ack.
REQ-017 timed_out  out  1  last frame was forced by trigger timeout.

Function
REQ-018 SHALL register adc_data every clock into adc_q, and keep previous strobe sample adc_prev.
REQ-019 SHALL implement states IDLE, ARM, WAIT_TRIG, CAPTURE, DONE.
REQ-020 IDLE: start=1 -> ARM; start ignored in every other state.
REQ-021 ARM: one cycle; clears decimation counter, strobe counter, timed_out; -> WAIT_TRIG if trig_en=1, else -> CAPTURE.
REQ-022 Strobe SHALL assert on the cycle decimation counter = DECIM-1 (every cycle when DECIM=1); counter wraps to 0.
REQ-023 WAIT_TRIG: on strobe, if adc_prev < trig_level and adc_q >= trig_level -> CAPTURE, and this crossing sample is written to address 0.
REQ-024 WAIT_TRIG: after TRIG_TIMEOUT strobes without crossing -> CAPTURE, timed_out set to 1; first write on the next strobe.
REQ-025 CAPTURE: each strobe writes adc_q; wr_en high exactly one cycle, wr_addr 0,1,...,DEPTH-1, no gaps or repeats.
REQ-026 wr_en, wr_addr, wr_data SHALL be registered; wr_data equals adc_data presented 2 cycles before wr_en high.
REQ-027 After write of address DEPTH-1 -> DONE; wr_addr SHALL not wrap within a frame.
REQ-028 DONE: frame_done=1; ack=1 -> IDLE, frame_done=0 next cycle; ack outside DONE ignored.
REQ-029 start and ack high simultaneously in DONE: ack honoured, start ignored (re-arm needs new start in IDLE).
REQ-030 trig_en and trig_level SHALL be sampled in ARM and held constant for the frame.
REQ-031 Comparisons SHALL be unsigned DW-bit; trig_level=0 never produces a crossing (adc_prev < 0 impossible), so only timeout ends WAIT_TRIG.

Reset
REQ-032 sys_rst=1 SHALL immediately force IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, timed_out=0, all counters and adc_q/adc_prev=0.
REQ-033 Reset mid-CAPTURE SHALL abort frame; no further wr_en until a new start after reset release.

Verification (AW=4, DW=12)
REQ-034 DECIM=1, trig_en=0, ramp adc_data=n at cycle n, start -> 16 writes on consecutive cycles, addr 0..15, data increments by 1, frame_done then set; ack -> busy=0.
REQ-035 DECIM=4, trig_en=0 -> wr_en every 4th cycle, exactly 16 pulses, addresses contiguous.
REQ-036 trig_en=1, trig_level=2048, sawtooth 0..4095 step 64 -> addr 0 data is first sample >=2048 after a sample <2048 (2048); timed_out=0.
REQ-037 trig_en=1, trig_level=4095, adc_data constant 100, TRIG_TIMEOUT=8 -> capture starts after 8 strobes, timed_out=1, 16 writes of 100.
REQ-038 sys_rst pulse after 5 writes -> all outputs 0 immediately, no writes until next start; full frame then completes normally.
REQ-039 start pulses during CAPTURE and DONE, ack during WAIT_TRIG -> no effect; start+ack together in DONE -> IDLE.
